// File: rtl/tdm_bit_distributor_pkg.sv
// Shared definitions for the TDM bit distributor.
//   NCH           : number of output channels
//   mode_e        : SCAN (rotating pointer) / FIXED (address from sel)
//   onehot_to_idx : converts an 8-bit one-hot pointer to its 3-bit index
package tdm_bit_distributor_pkg;

  localparam int unsigned NCH = 8;

  typedef enum logic {
    SCAN  = 1'b0,
    FIXED = 1'b1
  } mode_e;

  function automatic logic [2:0] onehot_to_idx(input logic [NCH-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tdm_bit_distributor_tick_gen.sv
// Free-running divider producing a single-cycle enable every DIV clocks.
//   clk     : system clock
//   rst_n   : synchronous active-low reset (counter cleared to 0)
//   tick_en : high while counter == DIV-1 (combinational)
module tick_gen #(
  parameter int unsigned DIV = 4194304,
  parameter int unsigned CW  = 22
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_en
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick_en = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick_en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tdm_bit_distributor.sv
// 1-to-8 serial demultiplexer with per-channel storage and frame reassembly.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   din        : serial data bit, sampled once per tick
//   mode       : 0 = scan (rotating pointer), 1 = fixed (channel from sel)
//   sel        : channel address used in fixed mode
//   ch_onehot  : current channel pointer (one-hot)
//   dout       : per-channel latched data
//   frame_data : last completed 8-bit frame
//   frame_done : one-cycle pulse when frame_data updates
//   tick       : one-cycle strobe the cycle after each sample edge
module tdm_bit_distributor
  import tdm_bit_distributor_pkg::*;
#(
  parameter int unsigned DIV = 4194304,
  parameter int unsigned CW  = 22
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           din,
  input  logic           mode,
  input  logic [2:0]     sel,
  output logic [NCH-1:0] ch_onehot,
  output logic [NCH-1:0] dout,
  output logic [NCH-1:0] frame_data,
  output logic           frame_done,
  output logic           tick
);

  logic       tick_en;
  mode_e      cur_mode;
  logic [2:0] cur_idx;

  tick_gen #(
    .DIV (DIV),
    .CW  (CW)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (tick_en)
  );

  always_comb begin
    cur_mode = mode_e'(mode);
    cur_idx  = onehot_to_idx(ch_onehot);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_onehot  <= NCH'(1);
      dout       <= '0;
      frame_data <= '0;
      frame_done <= 1'b0;
      tick       <= 1'b0;
    end else begin
      tick       <= tick_en;
      frame_done <= 1'b0;
      if (tick_en) begin
        if (cur_mode == FIXED) begin
          dout[sel] <= din;
          ch_onehot <= NCH'(1) << sel;
        end else begin
          dout[cur_idx] <= din;
          ch_onehot     <= {ch_onehot[NCH-2:0], ch_onehot[NCH-1]};
          // Last channel: fold the incoming bit in directly since dout[7]
          // is only updated by this same edge.
          if (cur_idx == 3'd7) begin
            frame_data <= {din, dout[NCH-2:0]};
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_bit_distributor.sv
module tb_tdm_bit_distributor;

  typedef struct {
    logic       rst_before;
    logic       mode;
    logic [2:0] sel;
    logic       din;
    logic [7:0] ch;
    logic [7:0] dout;
    logic [7:0] fd;
    logic       done;
  } vec_t;

  localparam int NV = 29;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] ch_onehot, dout, frame_data;
  logic       frame_done, tick;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int prev_tick = 0;
  int last_done_cyc = 0;
  vec_t tbl [0:NV-1];
  vec_t exp_q [$];

  tdm_bit_distributor #(.DIV(4), .CW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .mode       (mode),
    .sel        (sel),
    .ch_onehot  (ch_onehot),
    .dout       (dout),
    .frame_data (frame_data),
    .frame_done (frame_done),
    .tick       (tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic r, input logic m, input logic [2:0] s,
                              input logic d, input logic [7:0] c, input logic [7:0] o,
                              input logic [7:0] f, input logic dn);
    vec_t v;
    v.rst_before = r; v.mode = m; v.sel = s; v.din = d;
    v.ch = c; v.dout = o; v.fd = f; v.done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_ch", ch_onehot, 8'h01);
    chk("rst_dout", dout, 8'h00);
    chk("rst_fd", frame_data, 8'h00);
    chk("rst_done", {7'd0, frame_done}, 8'h00);
    chk("rst_tick", {7'd0, tick}, 8'h00);
    rst_n = 1'b1;
    prev_tick = cyc;
  endtask

  // Waits (bounded) for the next tick; checks spacing and that frame_done
  // never appears outside a tick cycle.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (tick) begin
        chk_int("tick_spacing", cyc - prev_tick, 4);
        prev_tick = cyc;
        ok = 1'b1;
        break;
      end else begin
        chk("done_without_tick", {7'd0, frame_done}, 8'h00);
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: no tick within 8 clks (cycle %0d)", cyc);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    bit   ok;
    vec_t e;
    if (v.rst_before) do_reset(3);
    din  = v.din;
    mode = v.mode;
    sel  = v.sel;
    exp_q.push_back(v);
    wait_tick(ok);
    e = exp_q.pop_front();
    if (ok) begin
      chk("ch_onehot", ch_onehot, e.ch);
      chk("dout", dout, e.dout);
      chk("frame_data", frame_data, e.fd);
      chk("frame_done", {7'd0, frame_done}, {7'd0, e.done});
      if (frame_done) last_done_cyc = cyc;
    end
  endtask

  initial begin
    bit ok;
    int ndone;
    int a_cyc;

    // Scan A5 then 3C, LSB first
    tbl[0]  = mk(0, 0, 0, 1, 8'h02, 8'h01, 8'h00, 0);
    tbl[1]  = mk(0, 0, 0, 0, 8'h04, 8'h01, 8'h00, 0);
    tbl[2]  = mk(0, 0, 0, 1, 8'h08, 8'h05, 8'h00, 0);
    tbl[3]  = mk(0, 0, 0, 0, 8'h10, 8'h05, 8'h00, 0);
    tbl[4]  = mk(0, 0, 0, 0, 8'h20, 8'h05, 8'h00, 0);
    tbl[5]  = mk(0, 0, 0, 1, 8'h40, 8'h25, 8'h00, 0);
    tbl[6]  = mk(0, 0, 0, 0, 8'h80, 8'h25, 8'h00, 0);
    tbl[7]  = mk(0, 0, 0, 1, 8'h01, 8'hA5, 8'hA5, 1);
    tbl[8]  = mk(0, 0, 0, 0, 8'h02, 8'hA4, 8'hA5, 0);
    tbl[9]  = mk(0, 0, 0, 0, 8'h04, 8'hA4, 8'hA5, 0);
    tbl[10] = mk(0, 0, 0, 1, 8'h08, 8'hA4, 8'hA5, 0);
    tbl[11] = mk(0, 0, 0, 1, 8'h10, 8'hAC, 8'hA5, 0);
    tbl[12] = mk(0, 0, 0, 1, 8'h20, 8'hBC, 8'hA5, 0);
    tbl[13] = mk(0, 0, 0, 1, 8'h40, 8'hBC, 8'hA5, 0);
    tbl[14] = mk(0, 0, 0, 0, 8'h80, 8'hBC, 8'hA5, 0);
    tbl[15] = mk(0, 0, 0, 0, 8'h01, 8'h3C, 8'h3C, 1);
    // After mid-frame reset: restart at channel 0
    tbl[16] = mk(0, 0, 0, 1, 8'h02, 8'h01, 8'h00, 0);
    // Fixed mode from a clean reset
    tbl[17] = mk(1, 1, 5, 1, 8'h20, 8'h20, 8'h00, 0);
    tbl[18] = mk(0, 1, 5, 1, 8'h20, 8'h20, 8'h00, 0);
    tbl[19] = mk(0, 1, 5, 1, 8'h20, 8'h20, 8'h00, 0);
    tbl[20] = mk(0, 1, 2, 1, 8'h04, 8'h24, 8'h00, 0);
    // Fixed -> scan rewrites channel 2; sel ignored in scan mode
    tbl[21] = mk(0, 0, 7, 0, 8'h08, 8'h20, 8'h00, 0);
    tbl[22] = mk(0, 0, 7, 1, 8'h10, 8'h28, 8'h00, 0);
    tbl[23] = mk(0, 0, 7, 0, 8'h20, 8'h28, 8'h00, 0);
    tbl[24] = mk(0, 0, 7, 0, 8'h40, 8'h08, 8'h00, 0);
    tbl[25] = mk(0, 0, 7, 0, 8'h80, 8'h08, 8'h00, 0);
    tbl[26] = mk(0, 0, 7, 1, 8'h01, 8'h88, 8'h88, 1);
    // Scan -> fixed abandons partial frame
    tbl[27] = mk(0, 0, 0, 1, 8'h02, 8'h89, 8'h88, 0);
    tbl[28] = mk(0, 1, 0, 0, 8'h01, 8'h88, 8'h88, 0);

    do_reset(3);

    // 64 idle ticks: spacing must not drift; 8 full frames of zeros
    din = 1'b0; mode = 1'b0; sel = 3'd0;
    ndone = 0;
    for (int i = 0; i < 64; i++) begin
      wait_tick(ok);
      if (frame_done) ndone++;
    end
    chk_int("idle_frames", ndone, 8);
    chk("idle_ch", ch_onehot, 8'h01);
    chk("idle_dout", dout, 8'h00);

    // Back-to-back frames A5 / 3C
    a_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      apply_vec(tbl[i]);
      if (i == 7) a_cyc = last_done_cyc;
    end
    chk_int("frame_spacing", last_done_cyc - a_cyc, 32);
    @(negedge clk);
    chk("done_one_cycle", {7'd0, frame_done}, 8'h00);

    // Reset mid-frame after 4 scan ticks of 1s
    apply_vec(mk(0, 0, 0, 1, 8'h02, 8'h3D, 8'h3C, 0));
    apply_vec(mk(0, 0, 0, 1, 8'h04, 8'h3F, 8'h3C, 0));
    apply_vec(mk(0, 0, 0, 1, 8'h08, 8'h3F, 8'h3C, 0));
    apply_vec(mk(0, 0, 0, 1, 8'h10, 8'h3F, 8'h3C, 0));
    do_reset(1);

    for (int i = 16; i < NV; i++) apply_vec(tbl[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
